// File: rtl/bcd_add_sequencer.sv
// Digit-serial packed-BCD adder: one shared digit adder, LSD first, saturating to all nines.
// Latency DIGITS cycles from accept to out_valid; the result holds until out_ready, and no input is taken while busy.
module bcd_add_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  ovf,
    output logic                  bad_digit
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic [4*DIGITS-1:0] res_q, res_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic                bad_q, bad_d;
    logic                ovf_q, ovf_d;
    logic                bad_digit_q, bad_digit_d;

    logic [3:0]          a_dig, b_dig, dig;
    logic [4:0]          t;
    logic                c_nxt;
    logic                last;
    logic                in_bad;
    logic [4*DIGITS-1:0] res_upd;

    assign last = (cnt_q == CW'(DIGITS - 1));

    // Shared single-digit decimal adder operating on the digit selected by the counter.
    always_comb begin
        a_dig = 4'h0;
        b_dig = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        t = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        if (t > 5'd9) begin
            dig   = t[3:0] + 4'd6;
            c_nxt = 1'b1;
        end else begin
            dig   = t[3:0];
            c_nxt = 1'b0;
        end
        res_upd = res_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                res_upd[4*i +: 4] = dig;
            end
        end
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_ADD;
            ST_ADD:  if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state; the visible result is only rewritten on the final digit.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        bad_d       = bad_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        bad_digit_d = bad_digit_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = x;
                    b_d     = y;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    bad_d   = in_bad;
                end
            end
            ST_ADD: begin
                res_d   = res_upd;
                carry_d = c_nxt;
                if (last) begin
                    if (bad_q) begin
                        sum_d       = NINES;
                        ovf_d       = 1'b0;
                        bad_digit_d = 1'b1;
                    end else if (c_nxt) begin
                        sum_d       = NINES;
                        ovf_d       = 1'b1;
                        bad_digit_d = 1'b0;
                    end else begin
                        sum_d       = res_upd;
                        ovf_d       = 1'b0;
                        bad_digit_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            bad_q       <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            bad_digit_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            bad_q       <= bad_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            bad_digit_q <= bad_digit_d;
        end
    end

    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Scoreboard bench for bcd_add_sequencer: directed vectors, backpressure, busy-ignore, back-to-back and async reset.
module tb_bcd_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        ovf;
    logic        bad_digit;

    bcd_add_sequencer #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .bad_digit (bad_digit)
    );

    typedef struct {
        logic [15:0] s;
        logic        o;
        logic        b;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic        o;
        logic        b;
    } vec_t;

    exp_t sb[$];
    vec_t vt[0:8];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    bit   ov_prev  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        chk_cnt++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
    endtask

    task automatic send(input logic [15:0] xa, input logic [15:0] ya,
                        input logic [15:0] es, input logic eo, input logic eb, input bit push);
        int   n;
        exp_t e;
        x        = xa;
        y        = ya;
        in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) begin
            e.s   = es;
            e.o   = eo;
            e.b   = eb;
            e.acc = cyc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic wait_out_valid(input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now(nm);
    endtask

    // Monitor: latency on result arrival, data on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (sb.size() == 0) fail_now("unexpected_result");
                    else check("latency", 32'(cyc - sb[0].acc), 32'd4);
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", {14'd0, sum, ovf, bad_digit}, {14'd0, e.s, e.o, e.b});
                end
                ov_prev = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        vt[0] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vt[2] = '{16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0};
        vt[3] = '{16'h9999, 16'h0001, 16'h9999, 1'b1, 1'b0};
        vt[4] = '{16'h5000, 16'h5000, 16'h9999, 1'b1, 1'b0};
        vt[5] = '{16'h12A4, 16'h0001, 16'h9999, 1'b0, 1'b1};
        vt[6] = '{16'hF000, 16'h9000, 16'h9999, 1'b0, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[8] = '{16'h4567, 16'h4433, 16'h9000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        #12;
        check("reset_outputs", {13'd0, in_ready, out_valid, sum, ovf, bad_digit},
              {13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) send(vt[i].x, vt[i].y, vt[i].s, vt[i].o, vt[i].b, 1'b1);
        drain();

        // Backpressure: result must hold for three stalled cycles.
        out_ready = 1'b0;
        send(16'h2468, 16'h1357, 16'h3825, 1'b0, 1'b0, 1'b1);
        wait_out_valid("stall_wait");
        for (int k = 0; k < 3; k++) begin
            check("stall_hold", {12'd0, in_ready, out_valid, sum, ovf, bad_digit},
                  {12'd0, 1'b0, 1'b1, 16'h3825, 1'b0, 1'b0});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Busy: new operands during ADD/DONE must be ignored.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b1);
        x        = 16'h7777;
        y        = 16'h1111;
        in_valid = 1'b1;
        wait_out_valid("busy_wait");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (8) @(negedge clk);
        check("no_spurious", {31'd0, out_valid}, 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        gap = last_acc;
        send(16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b1);
        check("b2b_gap1", 32'(last_acc - gap), 32'd6);
        gap = last_acc;
        send(16'h0100, 16'h0900, 16'h1000, 1'b0, 1'b0, 1'b1);
        check("b2b_gap2", 32'(last_acc - gap), 32'd6);
        gap = last_acc;
        send(16'h8000, 16'h1999, 16'h9999, 1'b0, 1'b0, 1'b1);
        check("b2b_gap3", 32'(last_acc - gap), 32'd6);
        drain();

        // Async reset during the second ADD cycle discards the operation.
        x        = 16'h9999;
        y        = 16'h0001;
        in_valid = 1'b1;
        @(negedge clk);
        if (!in_ready) fail_now("rst_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset", {13'd0, in_ready, out_valid, sum, ovf, bad_digit},
              {13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
